cmd_sequencer: RTL
==================

CMD_SEQUENCER -- requirements
Module: cmd_sequencer

Interface
REQ-001 SHALL have parameter TMO_W, default 27, width of the per-command response timeout counter; timeout fires when the counter reaches all-ones.
REQ-002 SHALL have parameter ACK, default 8'hA5, the positive-acknowledge byte.
REQ-003 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port wr_en  input  1  write wr_data into the command store at wr_addr.
REQ-006 SHALL have port wr_addr  input  4  command store address, slots 0-15.
REQ-007 SHALL have port wr_data  input  16  command word, in the same format as RemoteComm cmd.
REQ-008 SHALL have port len  input  5  number of commands to play, sampled on start.
REQ-009 SHALL have port start  input  1  single-cycle request to begin playback from slot 0.
REQ-010 SHALL have port abort  input  1  single-cycle request to terminate playback.
REQ-011 SHALL have port cmd  output  16  command word to RemoteComm.
REQ-012 SHALL have port snd_cmd  output  1  single-cycle send strobe to RemoteComm.
REQ-013 SHALL have port cmd_snt  input  1  RemoteComm has finished transmitting both bytes.
REQ-014 SHALL have port resp_rdy  input  1  RemoteComm response byte valid; single-cycle pulse.
REQ-015 SHALL have port resp  input  8  response byte.
REQ-016 SHALL have port busy  output  1  high in every state other than IDLE.
REQ-017 SHALL have port done  output  1  single-cycle pulse when playback ends, whether it succeeds or fails.
REQ-018 SHALL have port err  output  1  last playback failed.
REQ-019 SHALL have port err_code  output  2  failure cause: 00 none, 01 NAK, 10 timeout, 11 abort.
REQ-020 SHALL have port cmd_idx  output  4  index of the current or last command issued.
REQ-021 SHALL have port ack_cnt  output  5  count of ACKs received in the current or last playback.

Function
REQ-022 SHALL hold a 16x16 command store; a write occurs only when wr_en=1 and busy=0, and writes while busy are dropped.
REQ-023 SHALL implement the states IDLE, SEND, WAIT_SNT and WAIT_RESP.
REQ-024 IDLE + start: latch min(len,16), clear err, err_code, cmd_idx and ack_cnt; if len=0, pulse done on the next cycle and stay in IDLE; otherwise go to SEND.
REQ-025 SEND: register cmd <= store[cmd_idx], assert snd_cmd for exactly 1 cycle, clear the timer, go to WAIT_SNT.
REQ-026 WAIT_SNT: on cmd_snt go to WAIT_RESP; the timer increments every cycle.
REQ-027 WAIT_RESP: the timer continues from its WAIT_SNT value and is not cleared between these two states.
REQ-028 WAIT_RESP + resp_rdy with resp==ACK: increment ack_cnt; if cmd_idx==latched_len-1, pulse done and go to IDLE; otherwise increment cmd_idx and go to SEND.
REQ-029 WAIT_RESP + resp_rdy with resp!=ACK: set err=1, err_code=01, pulse done, go to IDLE.
REQ-030 Timer all-ones in WAIT_SNT or WAIT_RESP: set err=1, err_code=10, pulse done, go to IDLE.
REQ-031 abort in any non-IDLE state: set err=1, err_code=11, pulse done, go to IDLE; abort in IDLE is ignored.
REQ-032 Simultaneous events SHALL resolve by priority: abort first, then timeout, then resp_rdy/cmd_snt.
REQ-033 start while busy SHALL be ignored.
REQ-034 resp_rdy outside WAIT_RESP and cmd_snt outside WAIT_SNT SHALL be ignored.
REQ-035 cmd SHALL stay stable from SEND until the next SEND or reset.
REQ-036 err, err_code, cmd_idx and ack_cnt SHALL hold their values after playback until the next accepted start.
REQ-037 All outputs SHALL be registered.

Reset
REQ-038 rst_n low SHALL immediately force: state IDLE, cmd=0, snd_cmd=0, busy=0, done=0, err=0, err_code=00, cmd_idx=0, ack_cnt=0, timer=0.
REQ-039 Reset mid-playback SHALL abandon playback without pulsing done.
REQ-040 Command store contents are not reset; they are undefined until written.

Verification
REQ-041 Load 16'h53F4, 16'h47F1, 16'h5BF4; len=3; start; model ACKs each -> three snd_cmd pulses carrying those words in order, done once, err=0, ack_cnt=3, cmd_idx=2.
REQ-042 len=3; respond 8'hA5 then 8'h5A -> after the 2nd response: done, err=1, err_code=01, ack_cnt=1, cmd_idx=1, no third snd_cmd.
REQ-043 TMO_W=8; withhold cmd_snt -> done exactly 255 cycles after SEND, err_code=10.
REQ-044 abort asserted in WAIT_RESP in the same cycle as an ACK resp_rdy -> err_code=11, ack_cnt unchanged, busy=0 on the next cycle.
REQ-045 len=0 with start -> done one cycle later, no snd_cmd, err=0.
REQ-046 wr_en to slot 0 while busy, then replay -> the original slot-0 word is sent.
REQ-047 Drop rst_n low during WAIT_SNT -> all outputs return to their reset values asynchronously and no done pulse occurs.

Source files
------------

// File: rtl/cmd_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cmd_sequencer : replays up to 16 stored commands through RemoteComm, |
// | each gated on an ACK byte under a per-command timeout.   Rev 1.0     |
// +----------------------------------------------------------------------+
module cmd_sequencer #(
  parameter int unsigned TMO_W = 27,
  parameter logic [7:0]  ACK   = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [3:0]  wr_addr,
  input  logic [15:0] wr_data,
  input  logic [4:0]  len,
  input  logic        start,
  input  logic        abort,
  output logic [15:0] cmd,
  output logic        snd_cmd,
  input  logic        cmd_snt,
  input  logic        resp_rdy,
  input  logic [7:0]  resp,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [3:0]  cmd_idx,
  output logic [4:0]  ack_cnt
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_SEND      = 2'd1,
    S_WAIT_SNT  = 2'd2,
    S_WAIT_RESP = 2'd3
  } state_t;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_NAK   = 2'b01;
  localparam logic [1:0] ERR_TMO   = 2'b10;
  localparam logic [1:0] ERR_ABORT = 2'b11;

  state_t             state_q, state_d;
  logic [15:0]        cmd_q, cmd_d;
  logic               snd_cmd_q, snd_cmd_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [1:0]         err_code_q, err_code_d;
  logic [3:0]         cmd_idx_q, cmd_idx_d;
  logic [4:0]         ack_cnt_q, ack_cnt_d;
  logic [4:0]         len_q, len_d;
  logic [TMO_W-1:0]   timer_q, timer_d;

  logic [15:0]        store_mem [16];

  logic [TMO_W-1:0]   w_tmr_inc;
  logic               w_tmo;
  logic               w_last;
  logic               fail;
  logic [1:0]         fail_code;

  always_ff @(posedge clk) begin
    if (wr_en && !busy_q) begin
      store_mem[wr_addr] <= wr_data;
    end
  end

  // Timeout fires on the cycle the counter steps onto all-ones, so the
  // first wait cycle after the send strobe counts as 0.
  assign w_tmr_inc = timer_q + TMO_W'(1);
  assign w_tmo     = &w_tmr_inc;
  assign w_last    = ({1'b0, cmd_idx_q} == (len_q - 5'd1));

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    snd_cmd_d  = 1'b0;
    done_d     = 1'b0;
    err_d      = err_q;
    err_code_d = err_code_q;
    cmd_idx_d  = cmd_idx_q;
    ack_cnt_d  = ack_cnt_q;
    len_d      = len_q;
    timer_d    = timer_q;
    fail       = 1'b0;
    fail_code  = ERR_NONE;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d      = (len > 5'd16) ? 5'd16 : len;
          err_d      = 1'b0;
          err_code_d = ERR_NONE;
          cmd_idx_d  = 4'd0;
          ack_cnt_d  = 5'd0;
          if (len == 5'd0) begin
            done_d = 1'b1;
          end else begin
            state_d = S_SEND;
          end
        end
      end
      S_SEND: begin
        if (abort) begin
          fail      = 1'b1;
          fail_code = ERR_ABORT;
        end else begin
          cmd_d     = store_mem[cmd_idx_q];
          snd_cmd_d = 1'b1;
          timer_d   = '0;
          state_d   = S_WAIT_SNT;
        end
      end
      S_WAIT_SNT: begin
        if (abort) begin
          fail      = 1'b1;
          fail_code = ERR_ABORT;
        end else if (w_tmo) begin
          fail      = 1'b1;
          fail_code = ERR_TMO;
        end else begin
          timer_d = w_tmr_inc;
          if (cmd_snt) begin
            state_d = S_WAIT_RESP;
          end
        end
      end
      S_WAIT_RESP: begin
        if (abort) begin
          fail      = 1'b1;
          fail_code = ERR_ABORT;
        end else if (w_tmo) begin
          fail      = 1'b1;
          fail_code = ERR_TMO;
        end else begin
          timer_d = w_tmr_inc;
          if (resp_rdy) begin
            if (resp == ACK) begin
              ack_cnt_d = ack_cnt_q + 5'd1;
              if (w_last) begin
                done_d  = 1'b1;
                state_d = S_IDLE;
              end else begin
                cmd_idx_d = cmd_idx_q + 4'd1;
                state_d   = S_SEND;
              end
            end else begin
              fail      = 1'b1;
              fail_code = ERR_NAK;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (fail) begin
      err_d      = 1'b1;
      err_code_d = fail_code;
      done_d     = 1'b1;
      state_d    = S_IDLE;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cmd_q      <= 16'h0000;
      snd_cmd_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
      cmd_idx_q  <= 4'd0;
      ack_cnt_q  <= 5'd0;
      len_q      <= 5'd0;
      timer_q    <= '0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      snd_cmd_q  <= snd_cmd_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      cmd_idx_q  <= cmd_idx_d;
      ack_cnt_q  <= ack_cnt_d;
      len_q      <= len_d;
      timer_q    <= timer_d;
    end
  end

  assign cmd      = cmd_q;
  assign snd_cmd  = snd_cmd_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign err_code = err_code_q;
  assign cmd_idx  = cmd_idx_q;
  assign ack_cnt  = ack_cnt_q;

endmodule
`default_nettype wire
